// File: rtl/rvm_gpio_pkg.sv
// Shared constants, FSM encodings and helper functions for the rvm_axi_gpio peripheral.
package rvm_gpio_pkg;

  localparam logic [11:0] OFF_LED     = 12'h000;
  localparam logic [11:0] OFF_RGB     = 12'h004;
  localparam logic [11:0] OFF_SW      = 12'h008;
  localparam logic [11:0] OFF_BTN     = 12'h00C;
  localparam logic [11:0] OFF_SCRATCH = 12'h010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // FIXED holds the offset; every other encoding advances one word, wrapping in 12 bits.
  function automatic logic [11:0] next_offset(input logic [11:0] off, input logic [1:0] burst);
    logic [11:0] nxt;
    if (burst == BURST_FIXED) begin
      nxt = off;
    end else begin
      nxt = off + 12'd4;
    end
    return nxt;
  endfunction

  function automatic logic is_mapped(input logic [11:0] off);
    logic hit;
    case ({off[11:2], 2'b00})
      OFF_LED, OFF_RGB, OFF_SW, OFF_BTN, OFF_SCRATCH: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        res[8*i +: 8] = data[8*i +: 8];
      end else begin
        res[8*i +: 8] = cur[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rvm_gpio_debounce.sv
// Single-bit 2-flop synchronizer with an optional consecutive-cycle debounce stage.
module rvm_gpio_debounce
  import rvm_gpio_pkg::*;
#(
  parameter bit          DEBOUNCE_EN     = 1'b0,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [1:0] sync_r;

  // Two-stage synchronizer for the asynchronous board input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], din};
    end
  end

  generate
    if (DEBOUNCE_EN) begin : g_deb
      logic [19:0] cnt_r;
      logic        state_r;

      // Commit a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_r   <= 20'd0;
          state_r <= 1'b0;
        end else if (sync_r[1] != state_r) begin
          if (cnt_r >= DEBOUNCE_CYCLES - 20'd1) begin
            state_r <= sync_r[1];
            cnt_r   <= 20'd0;
          end else begin
            cnt_r <= cnt_r + 20'd1;
          end
        end else begin
          cnt_r <= 20'd0;
        end
      end

      assign dout = state_r;
    end else begin : g_raw
      assign dout = sync_r[1];
    end
  endgenerate

endmodule

// File: rtl/rvm_axi_gpio.sv
// AXI4 slave GPIO block: LED/RGB/SCRATCH registers, synchronized switches and buttons.
// Optional button debounce is enabled by defining RVM_GPIO_DEBOUNCE_EN.
module rvm_axi_gpio
  import rvm_gpio_pkg::*;
#(
  parameter logic [31:0] SCRATCH_RST     = 32'h0000_0000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd100000
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        AWID,
  input  logic [11:0] AWADDR,
  input  logic [7:0]  AWLEN,
  input  logic [1:0]  AWBURST,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WLAST,
  input  logic        WVALID,
  output logic        WREADY,
  output logic        BID,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic        ARID,
  input  logic [11:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [1:0]  ARBURST,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic        RID,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY,
  input  logic [3:0]  sw,
  input  logic [3:0]  btn,
  output logic [2:0]  led,
  output logic [2:0]  rgb0,
  output logic [2:0]  rgb1,
  output logic [2:0]  rgb2,
  output logic [2:0]  rgb3
);

`ifdef RVM_GPIO_DEBOUNCE_EN
  localparam bit BTN_DEB_EN = 1'b1;
`else
  localparam bit BTN_DEB_EN = 1'b0;
`endif

  wr_state_t   w_state_r;
  rd_state_t   r_state_r;
  logic [11:0] waddr_r;
  logic [1:0]  wburst_r;
  logic        werr_r;
  logic [11:0] raddr_r;
  logic [1:0]  rburst_r;
  logic [7:0]  rcnt_r;
  logic [2:0]  led_r;
  logic [11:0] rgb_r;
  logic [31:0] scratch_r;
  logic [3:0]  sw_s;
  logic [3:0]  btn_s;
  logic [11:0] wword_s;
  logic        wr_en_s;
  logic [31:0] cur_s;
  logic [31:0] merged_s;
  logic [11:0] rd_addr_s;
  logic [31:0] rd_data_s;
  logic [1:0]  rd_resp_s;
  logic        unused_s;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_in
      rvm_gpio_debounce #(.DEBOUNCE_EN(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk(ACLK), .rst_n(ARESETn), .din(sw[gi]), .dout(sw_s[gi])
      );
      rvm_gpio_debounce #(.DEBOUNCE_EN(BTN_DEB_EN), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk(ACLK), .rst_n(ARESETn), .din(btn[gi]), .dout(btn_s[gi])
      );
    end
  endgenerate

  // Burst length is not tracked: WLAST alone ends a write burst.
  assign unused_s = ^{AWLEN, waddr_r[1:0], rd_addr_s[1:0]};

  assign wword_s = {waddr_r[11:2], 2'b00};
  assign wr_en_s = (w_state_r == W_DATA) && WVALID && WREADY;

  // Byte-merge the incoming beat with the currently addressed register.
  always_comb begin
    cur_s = 32'h0000_0000;
    case (wword_s)
      OFF_LED:     cur_s = {29'h0, led_r};
      OFF_RGB:     cur_s = {20'h0, rgb_r};
      OFF_SCRATCH: cur_s = scratch_r;
      default:     cur_s = 32'h0000_0000;
    endcase
    merged_s = apply_strb(cur_s, WDATA, WSTRB);
  end

  // Write channel FSM with registered handshake and response outputs.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_r <= W_IDLE;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      BID       <= 1'b0;
      waddr_r   <= 12'h000;
      wburst_r  <= BURST_INCR;
      werr_r    <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (AWVALID && AWREADY) begin
            BID       <= AWID;
            waddr_r   <= AWADDR;
            wburst_r  <= AWBURST;
            werr_r    <= 1'b0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b1;
            w_state_r <= W_DATA;
          end else begin
            AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            waddr_r <= next_offset(waddr_r, wburst_r);
            werr_r  <= werr_r | ~is_mapped(waddr_r);
            if (WLAST) begin
              WREADY    <= 1'b0;
              BVALID    <= 1'b1;
              BRESP     <= (werr_r | ~is_mapped(waddr_r)) ? RESP_DECERR : RESP_OKAY;
              w_state_r <= W_RESP;
            end else begin
              WREADY <= 1'b1;
            end
          end else begin
            WREADY <= 1'b1;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            AWREADY   <= 1'b1;
            w_state_r <= W_IDLE;
          end else begin
            BVALID <= 1'b1;
          end
        end
        default: begin
          AWREADY   <= 1'b0;
          WREADY    <= 1'b0;
          BVALID    <= 1'b0;
          w_state_r <= W_IDLE;
        end
      endcase
    end
  end

  // Writable registers; beats to SW/BTN or unmapped offsets leave them untouched.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      led_r     <= 3'b000;
      rgb_r     <= 12'h000;
      scratch_r <= SCRATCH_RST;
    end else if (wr_en_s) begin
      case (wword_s)
        OFF_LED:     led_r     <= merged_s[2:0];
        OFF_RGB:     rgb_r     <= merged_s[11:0];
        OFF_SCRATCH: scratch_r <= merged_s;
        default:     scratch_r <= scratch_r;
      endcase
    end else begin
      scratch_r <= scratch_r;
    end
  end

  // Read mux: first beat decodes ARADDR, later beats decode the advanced offset.
  always_comb begin
    if (r_state_r == R_IDLE) begin
      rd_addr_s = ARADDR;
    end else begin
      rd_addr_s = next_offset(raddr_r, rburst_r);
    end
    rd_data_s = 32'h0000_0000;
    rd_resp_s = RESP_OKAY;
    case ({rd_addr_s[11:2], 2'b00})
      OFF_LED:     rd_data_s = {29'h0, led_r};
      OFF_RGB:     rd_data_s = {20'h0, rgb_r};
      OFF_SW:      rd_data_s = {28'h0, sw_s};
      OFF_BTN:     rd_data_s = {28'h0, btn_s};
      OFF_SCRATCH: rd_data_s = scratch_r;
      default:     rd_resp_s = RESP_DECERR;
    endcase
  end

  // Read channel FSM; beat outputs are only reloaded on a handshake, so stalls hold them.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_r <= R_IDLE;
      ARREADY   <= 1'b0;
      RVALID    <= 1'b0;
      RDATA     <= 32'h0000_0000;
      RRESP     <= RESP_OKAY;
      RLAST     <= 1'b0;
      RID       <= 1'b0;
      raddr_r   <= 12'h000;
      rburst_r  <= BURST_INCR;
      rcnt_r    <= 8'd0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            RID       <= ARID;
            raddr_r   <= ARADDR;
            rburst_r  <= ARBURST;
            rcnt_r    <= ARLEN;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b1;
            RDATA     <= rd_data_s;
            RRESP     <= rd_resp_s;
            RLAST     <= (ARLEN == 8'd0);
            r_state_r <= R_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY && RLAST) begin
            RVALID    <= 1'b0;
            RLAST     <= 1'b0;
            ARREADY   <= 1'b1;
            r_state_r <= R_IDLE;
          end else if (RREADY) begin
            raddr_r <= rd_addr_s;
            rcnt_r  <= rcnt_r - 8'd1;
            RDATA   <= rd_data_s;
            RRESP   <= rd_resp_s;
            RLAST   <= (rcnt_r == 8'd1);
          end else begin
            RVALID <= 1'b1;
          end
        end
        default: begin
          ARREADY   <= 1'b0;
          RVALID    <= 1'b0;
          RLAST     <= 1'b0;
          r_state_r <= R_IDLE;
        end
      endcase
    end
  end

  assign led  = led_r;
  assign rgb0 = rgb_r[2:0];
  assign rgb1 = rgb_r[5:3];
  assign rgb2 = rgb_r[8:6];
  assign rgb3 = rgb_r[11:9];

endmodule

// File: tb/tb_rvm_axi_gpio.sv
// Directed self-checking bench for rvm_axi_gpio (covers RVM_GPIO_DEBOUNCE_EN builds too).
module tb_rvm_axi_gpio;

  localparam logic [31:0] SCR_RST = 32'h1234_5678;

  logic        ACLK, ARESETn;
  logic        AWID, AWVALID, AWREADY;
  logic [11:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [1:0]  AWBURST;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic        BID, BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARID, ARVALID, ARREADY;
  logic [11:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [1:0]  ARBURST;
  logic        RID, RLAST, RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic [3:0]  sw, btn;
  logic [2:0]  led, rgb0, rgb1, rgb2, rgb3;

  int checks = 0;
  int failures = 0;
  logic [31:0] wr_data [16];
  logic [31:0] exp_data [16];
  logic [1:0]  exp_resp [16];
  logic [1:0]  bresp_v;
  logic        bid_v;

  rvm_axi_gpio #(.SCRATCH_RST(SCR_RST), .DEBOUNCE_CYCLES(20'd8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .sw(sw), .btn(btn), .led(led), .rgb0(rgb0), .rgb1(rgb1), .rgb2(rgb2), .rgb3(rgb3)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic write_burst(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic id, input logic [3:0] strb,
                             output logic [1:0] resp, output logic bid);
    int n;
    AWADDR = addr; AWLEN = len; AWBURST = burst; AWID = id; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin step(); n++; end
    check("aw_handshake", {31'b0, n < 50}, 32'd1);
    step();
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WDATA = wr_data[b]; WSTRB = strb; WLAST = (b == int'(len)); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 50) begin step(); n++; end
      check("w_handshake", {31'b0, n < 50}, 32'd1);
      step();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 50) begin step(); n++; end
    check("b_handshake", {31'b0, n < 50}, 32'd1);
    resp = BRESP; bid = BID;
    step();
    BREADY = 1'b0;
  endtask

  task automatic read_burst(input logic [11:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic id, input logic stall);
    int n, beats, cyc;
    ARADDR = addr; ARLEN = len; ARBURST = burst; ARID = id; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin step(); n++; end
    check("ar_handshake", {31'b0, n < 50}, 32'd1);
    step();
    ARVALID = 1'b0;
    check("r_first_latency", {31'b0, RVALID}, 32'd1);
    beats = 0; cyc = 0;
    while (beats <= int'(len) && cyc < 200) begin
      RREADY = stall ? ((cyc % 2) == 1) : 1'b1;
      if (RVALID) begin
        check($sformatf("rdata_%0h_b%0d", addr, beats), RDATA, exp_data[beats]);
        check($sformatf("rresp_%0h_b%0d", addr, beats), {30'b0, RRESP}, {30'b0, exp_resp[beats]});
        check($sformatf("rlast_%0h_b%0d", addr, beats), {31'b0, RLAST}, {31'b0, beats == int'(len)});
        check($sformatf("rid_%0h_b%0d", addr, beats), {31'b0, RID}, {31'b0, id});
        if (RREADY) beats++;
      end
      step();
      cyc++;
    end
    RREADY = 1'b0;
    check("r_beat_count", beats, int'(len) + 1);
    check("r_valid_after_last", {31'b0, RVALID}, 32'd0);
  endtask

  initial begin
    ARESETn = 1'b0;
    AWID = 1'b0; AWADDR = 12'h000; AWLEN = 8'd0; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = 32'h0; WSTRB = 4'h0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = 1'b0; ARADDR = 12'h000; ARLEN = 8'd0; ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b0;
    sw = 4'b0000; btn = 4'b0000;
    step(); step(); step();
    check("rst_awready", {31'b0, AWREADY}, 32'd0);
    check("rst_arready", {31'b0, ARREADY}, 32'd0);
    check("rst_bvalid", {31'b0, BVALID}, 32'd0);
    check("rst_rvalid", {31'b0, RVALID}, 32'd0);
    check("rst_rdata", RDATA, 32'd0);
    check("rst_led", {29'b0, led}, 32'd0);
    check("rst_rgb", {20'b0, rgb3, rgb2, rgb1, rgb0}, 32'd0);
    ARESETn = 1'b1;
    step();
    check("idle_awready", {31'b0, AWREADY}, 32'd1);
    check("idle_arready", {31'b0, ARREADY}, 32'd1);
    check("idle_wready", {31'b0, WREADY}, 32'd0);

    // 1: scratch reset value
    exp_data[0] = SCR_RST; exp_resp[0] = 2'b00;
    read_burst(12'h010, 8'd0, 2'b01, 1'b0, 1'b0);

    // 2: RGB partial-strobe writes
    wr_data[0] = 32'h0000_0ABC;
    write_burst(12'h004, 8'd0, 2'b01, 1'b1, 4'b0011, bresp_v, bid_v);
    check("rgb_bresp", {30'b0, bresp_v}, 32'd0);
    check("rgb_bid", {31'b0, bid_v}, 32'd1);
    check("rgb0", {29'b0, rgb0}, 32'd4);
    check("rgb1", {29'b0, rgb1}, 32'd7);
    check("rgb2", {29'b0, rgb2}, 32'd2);
    check("rgb3", {29'b0, rgb3}, 32'd5);
    wr_data[0] = 32'hFFFF_F123;
    write_burst(12'h004, 8'd0, 2'b01, 1'b0, 4'b0001, bresp_v, bid_v);
    check("rgb_strb1", {20'b0, rgb3, rgb2, rgb1, rgb0}, 32'h0000_0A23);

    // 3: 5-beat INCR write then stalled readback
    wr_data[0] = 32'h7; wr_data[1] = 32'hFFF; wr_data[2] = 32'h0; wr_data[3] = 32'h0;
    wr_data[4] = 32'hDEAD_BEEF;
    write_burst(12'h000, 8'd4, 2'b01, 1'b0, 4'hF, bresp_v, bid_v);
    check("incr_bresp", {30'b0, bresp_v}, 32'd0);
    check("incr_led", {29'b0, led}, 32'd7);
    exp_data[0] = 32'h7; exp_data[1] = 32'hFFF; exp_data[2] = 32'h0; exp_data[3] = 32'h0;
    exp_data[4] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) exp_resp[i] = 2'b00;
    read_burst(12'h000, 8'd4, 2'b01, 1'b0, 1'b1);

    // 4: unmapped FIXED read, then error writes
    for (int i = 0; i < 3; i++) begin exp_data[i] = 32'h0; exp_resp[i] = 2'b11; end
    read_burst(12'h020, 8'd2, 2'b00, 1'b1, 1'b0);
    wr_data[0] = 32'h55;
    write_burst(12'h024, 8'd0, 2'b01, 1'b1, 4'hF, bresp_v, bid_v);
    check("unmapped_bresp", {30'b0, bresp_v}, 32'd3);
    check("unmapped_bid", {31'b0, bid_v}, 32'd1);
    wr_data[0] = 32'hCAFE_F00D; wr_data[1] = 32'h99;
    write_burst(12'h010, 8'd1, 2'b01, 1'b0, 4'hF, bresp_v, bid_v);
    check("partial_err_bresp", {30'b0, bresp_v}, 32'd3);
    exp_data[0] = 32'hCAFE_F00D; exp_resp[0] = 2'b00;
    read_burst(12'h010, 8'd0, 2'b01, 1'b0, 1'b0);
    wr_data[0] = 32'h1111_1111; wr_data[1] = 32'h2222_2222;
    write_burst(12'h010, 8'd1, 2'b00, 1'b0, 4'hF, bresp_v, bid_v);
    check("fixed_bresp", {30'b0, bresp_v}, 32'd0);
    exp_data[0] = 32'h2222_2222; exp_data[1] = 32'h2222_2222;
    exp_resp[0] = 2'b00; exp_resp[1] = 2'b00;
    read_burst(12'h013, 8'd1, 2'b00, 1'b1, 1'b0);

    // 5: switches and buttons
    sw = 4'b1010;
    step(); step(); step();
    exp_data[0] = 32'hA; exp_resp[0] = 2'b00;
    read_burst(12'h008, 8'd0, 2'b01, 1'b0, 1'b0);
`ifdef RVM_GPIO_DEBOUNCE_EN
    btn = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    btn = 4'b0000;
    for (int i = 0; i < 10; i++) step();
    exp_data[0] = 32'h0;
    read_burst(12'h00C, 8'd0, 2'b01, 1'b0, 1'b0);
    btn = 4'b0001;
    for (int i = 0; i < 12; i++) step();
    btn = 4'b0000;
    exp_data[0] = 32'h1;
    read_burst(12'h00C, 8'd0, 2'b01, 1'b0, 1'b0);
`else
    btn = 4'b0110;
    step(); step(); step();
    exp_data[0] = 32'h6;
    read_burst(12'h00C, 8'd0, 2'b01, 1'b0, 1'b0);
    btn = 4'b0000;
`endif

    // 6: reset during beat 2 of a 4-beat read
    ARADDR = 12'h000; ARLEN = 8'd3; ARBURST = 2'b01; ARID = 1'b0; ARVALID = 1'b1;
    step();
    ARVALID = 1'b0;
    check("pre_rst_rvalid", {31'b0, RVALID}, 32'd1);
    RREADY = 1'b1;
    step();
    check("beat2_rvalid", {31'b0, RVALID}, 32'd1);
    check("beat2_rlast", {31'b0, RLAST}, 32'd0);
    RREADY = 1'b0;
    ARESETn = 1'b0;
    #1;
    check("mid_rst_rvalid", {31'b0, RVALID}, 32'd0);
    check("mid_rst_led", {29'b0, led}, 32'd0);
    step(); step();
    ARESETn = 1'b1;
    check("rel_arready", {31'b0, ARREADY}, 32'd0);
    step();
    check("post_rel_arready", {31'b0, ARREADY}, 32'd1);
    exp_data[0] = SCR_RST; exp_resp[0] = 2'b00;
    read_burst(12'h010, 8'd0, 2'b01, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
